shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Command sequencer for the 8-bit multi-mode shift register.
- Accepts shift commands through a valid/ready handshake and buffers them in a 2-entry FIFO.
- For each command, drives the register's enable, shift_direction and data_in for a programmed number of cycles, then pulses done.
- Sits between a host/CSR front end and the shift register; owns all sequencing of that datapath.

Parameters:
- CNT_W, 4, width of the per-command cycle count; max count = 2**CNT_W-1.
- DATA_W, 8, width of the data word forwarded to the shift register's data_in.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO not full; the command transfers when cmd_valid&cmd_ready.
- cmd_op  input  3  mode code, passed unmodified to sr_shift_direction.
- cmd_count  input  CNT_W  number of enabled shift cycles.
- cmd_data  input  DATA_W  parallel data for load-type modes.
- sr_enable  output  1  to shift register enable.
- sr_shift_direction  output  3  to shift register shift_direction.
- sr_data_in  output  DATA_W  to shift register data_in.
- busy  output  1  state != IDLE or FIFO non-empty.
- done  output  1  one-cycle pulse at command completion.

Behaviour:
- Reset (reset=0 at a clock edge):
  - FIFO emptied; state=IDLE.
  - sr_enable=0, sr_shift_direction=0, sr_data_in=0, done=0, busy=0; cmd_ready=1 from the first cycle after reset.
  - Reset mid-RUN aborts immediately; no done pulse is issued.
- FIFO:
  - 2 entries of {op, count, data}; cmd_ready = !full.
  - Push and pop in the same cycle are legal, including when full: the pop frees a slot, but cmd_ready is still 0 that cycle because it is based on registered full.
  - Push while full never occurs.
- FSM states IDLE, RUN, DONE:
  - IDLE: if FIFO non-empty, pop the head and register op, data and count into the sr_* drivers and the internal down-counter in the same cycle. If count≠0 go to RUN, else go to DONE. If the FIFO is empty, stay in IDLE.
  - RUN: sr_enable=1 every cycle; counter decrements. Move to DONE in the cycle where the counter equals 1.
  - DONE: sr_enable=0, done=1 for exactly one cycle, then IDLE.
- All outputs are registered. sr_shift_direction and sr_data_in change only at pop and hold their values through RUN, DONE and IDLE.
- Timing: a command accepted at cycle T into an idle, empty controller:
  - popped at T+1;
  - sr_enable high T+2..T+1+count;
  - done at T+2+count.
- count=0: no enable cycles; done at T+2.
- Back-to-back commands: the next pop happens in the IDLE cycle after DONE, giving 2 overhead cycles per command. sr_enable is never high in the cycle done=1.
- busy drops in the cycle after done only if the FIFO is empty.

Optional Feature:
- Macro SHIFT_SEQ_ABORT_EN.
- Defined: adds input abort (1 bit). abort=1 in any state:
  - flushes the FIFO;
  - in RUN, sr_enable deasserts next cycle, the FSM goes to DONE, and done pulses once;
  - in IDLE, only the flush happens and there is no done.
  - abort takes priority over a simultaneous push; that command is dropped.
- Undefined: no abort port; commands always run to completion.

Test Plan:
- Reset: hold reset=0 for 3 cycles with cmd_valid=1 -> sr_enable=0, sr_shift_direction=0, sr_data_in=0, done=0, busy=0, no command captured; cmd_ready=1 after release.
- Single command op=3'b011, count=5, data=8'hA5 accepted at T -> sr_shift_direction=3'b011 and sr_data_in=8'hA5 from T+2, sr_enable high T+2..T+6, done at T+7, busy low at T+8.
- count=0 with op=3'b100 accepted at T -> sr_enable never high, done at T+2.
- Three commands (counts 2,1,3) offered back-to-back with cmd_valid held -> cmd_ready drops when the FIFO is full; enable bursts of 2,1,3 cycles separated by the done cycle and an IDLE cycle; 3 done pulses; ops appear in order.
- Reset asserted during RUN of count=15 at its 4th enable cycle -> sr_enable=0 next cycle, no done, FIFO empty.
- With SHIFT_SEQ_ABORT_EN: abort at 2nd enable of count=8 with one queued command -> sr_enable low next cycle, done pulses once, queued command never executes, busy low afterwards.

Source files
------------

// File: rtl/shift_seq_ctrl_if.sv
// Command and shift-register drive bundle for shift_seq_ctrl.
// The abort line only exists when SHIFT_SEQ_ABORT_EN is defined.
interface shift_seq_ctrl_if #(
  parameter int CNT_W  = 4,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [CNT_W-1:0]  cmd_count;
  logic [DATA_W-1:0] cmd_data;
  logic              sr_enable;
  logic [2:0]        sr_shift_direction;
  logic [DATA_W-1:0] sr_data_in;
  logic              busy;
  logic              done;
`ifdef SHIFT_SEQ_ABORT_EN
  logic              abort;

  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_data, abort,
    input  cmd_ready, sr_enable, sr_shift_direction, sr_data_in, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_data, abort,
    output cmd_ready, sr_enable, sr_shift_direction, sr_data_in, busy, done
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_data,
    input  cmd_ready, sr_enable, sr_shift_direction, sr_data_in, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_data,
    output cmd_ready, sr_enable, sr_shift_direction, sr_data_in, busy, done
  );
`endif
endinterface

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for the multi-mode shift register: 2-entry command FIFO feeding an IDLE/RUN/DONE FSM.
// Define SHIFT_SEQ_ABORT_EN to add the abort input (flushes the FIFO and cuts a running command short).
module shift_seq_ctrl #(
  parameter int CNT_W  = 4,
  parameter int DATA_W = 8
) (
  input logic             clk,
  input logic             reset,
  shift_seq_ctrl_if.slave bus
);
  localparam int ENTRY_W = 3 + CNT_W + DATA_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [ENTRY_W-1:0]  r_mem [2];
  logic                r_wrPtr;
  logic                r_rdPtr;
  logic [1:0]          r_fill;
  logic [1:0]          w_nextFill;
  logic                r_cmdReady;
  logic                r_srEnable;
  logic                r_done;
  logic                r_busy;
  logic [2:0]          r_srDir;
  logic [DATA_W-1:0]   r_srData;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_nextEnable;
  logic                w_nextDone;
  logic [2:0]          w_nextDir;
  logic [DATA_W-1:0]   w_nextData;
  logic [CNT_W-1:0]    w_nextCnt;
  logic                w_abort;
  logic                w_push;
  logic                w_pop;
  logic [2:0]          w_headOp;
  logic [CNT_W-1:0]    w_headCnt;
  logic [DATA_W-1:0]   w_headData;

`ifdef SHIFT_SEQ_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  // Abort wins over both a simultaneous push and the IDLE pop.
  assign w_push     = bus.cmd_valid && r_cmdReady && !w_abort;
  assign w_pop      = (r_state == IDLE) && (r_fill != 2'd0) && !w_abort;
  assign {w_headOp, w_headCnt, w_headData} = r_mem[r_rdPtr];
  assign w_nextFill = w_abort ? 2'd0 : (r_fill + {1'b0, w_push} - {1'b0, w_pop});

  always_comb begin
    w_nextState  = r_state;
    w_nextEnable = r_srEnable;
    w_nextDone   = 1'b0;
    w_nextDir    = r_srDir;
    w_nextData   = r_srData;
    w_nextCnt    = r_cnt;
    case (r_state)
      IDLE: begin
        w_nextEnable = 1'b0;
        if (w_pop) begin
          w_nextDir  = w_headOp;
          w_nextData = w_headData;
          w_nextCnt  = w_headCnt;
          if (w_headCnt != '0) begin
            w_nextState  = RUN;
            w_nextEnable = 1'b1;
          end else begin
            w_nextState = DONE;
            w_nextDone  = 1'b1;
          end
        end
      end
      RUN: begin
        w_nextCnt = r_cnt - 1'b1;
        if (w_abort || (r_cnt == CNT_W'(1))) begin
          w_nextState  = DONE;
          w_nextEnable = 1'b0;
          w_nextDone   = 1'b1;
        end
      end
      DONE: begin
        w_nextState  = IDLE;
        w_nextEnable = 1'b0;
      end
      default: begin
        w_nextState  = IDLE;
        w_nextEnable = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr    <= 1'b0;
      r_rdPtr    <= 1'b0;
      r_fill     <= 2'd0;
      r_cmdReady <= 1'b1;
      r_srEnable <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_srDir    <= 3'd0;
      r_srData   <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_abort) begin
        r_wrPtr <= 1'b0;
        r_rdPtr <= 1'b0;
      end else begin
        if (w_push) r_wrPtr <= !r_wrPtr;
        if (w_pop)  r_rdPtr <= !r_rdPtr;
      end
      r_fill     <= w_nextFill;
      r_cmdReady <= (w_nextFill != 2'd2);
      r_srEnable <= w_nextEnable;
      r_done     <= w_nextDone;
      r_busy     <= (w_nextState != IDLE) || (w_nextFill != 2'd0);
      r_srDir    <= w_nextDir;
      r_srData   <= w_nextData;
      r_cnt      <= w_nextCnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem[r_wrPtr] <= {bus.cmd_op, bus.cmd_count, bus.cmd_data};
    end
  end

  assign bus.cmd_ready          = r_cmdReady;
  assign bus.sr_enable          = r_srEnable;
  assign bus.sr_shift_direction = r_srDir;
  assign bus.sr_data_in         = r_srData;
  assign bus.busy               = r_busy;
  assign bus.done               = r_done;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level schedule model.
module tb_shift_seq_ctrl;
  localparam int CNT_W  = 4;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.CNT_W(CNT_W), .DATA_W(DATA_W)) bus ();
  shift_seq_ctrl #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [2:0] op;
    logic [3:0] cnt;
    logic [7:0] data;
    logic       eRdy;
    logic       eEn;
    logic [2:0] eDir;
    logic [7:0] eData;
    logic       eDone;
    logic       eBusy;
  } vec_t;

  typedef struct {
    logic [2:0] op;
    int         cnt;
    logic [7:0] data;
    int         acc;
    int         pop;
  } cmd_t;

  cmd_t modelQ[$];
  int   lastDone;

  task automatic applyStimulus(input logic rst, input logic valid, input logic [2:0] op,
                               input logic [3:0] cnt, input logic [7:0] data);
    reset         = rst;
    bus.cmd_valid = valid;
    bus.cmd_op    = op;
    bus.cmd_count = cnt;
    bus.cmd_data  = data;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic rdy, input logic en, input logic [2:0] dir,
                          input logic [7:0] data, input logic dn, input logic bsy);
    checkOutput({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'(rdy));
    checkOutput({tag, ".sr_enable"}, 32'(bus.sr_enable), 32'(en));
    checkOutput({tag, ".sr_dir"}, 32'(bus.sr_shift_direction), 32'(dir));
    checkOutput({tag, ".sr_data"}, 32'(bus.sr_data_in), 32'(data));
    checkOutput({tag, ".done"}, 32'(bus.done), 32'(dn));
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Each command is served as: pop cycle, count enable cycles, one done cycle; the next pop can
  // happen the cycle after done, or the cycle after acceptance if the controller is already free.
  function automatic void modelAt(input int c, output logic rdy, output logic en, output logic [2:0] dir,
                                  output logic [7:0] data, output logic dn, output logic bsy);
    int occ;
    logic active;
    occ = 0;
    active = 1'b0;
    en = 1'b0;
    dn = 1'b0;
    dir = 3'd0;
    data = 8'd0;
    foreach (modelQ[i]) begin
      if (modelQ[i].acc < c) occ++;
      if (modelQ[i].pop < c) begin
        occ--;
        dir  = modelQ[i].op;
        data = modelQ[i].data;
      end
      if ((c > modelQ[i].pop) && (c <= modelQ[i].pop + modelQ[i].cnt)) en = 1'b1;
      if (c == modelQ[i].pop + modelQ[i].cnt + 1) dn = 1'b1;
      if ((c > modelQ[i].pop) && (c <= modelQ[i].pop + modelQ[i].cnt + 1)) active = 1'b1;
    end
    rdy = (occ != 2);
    bsy = (occ > 0) || active;
  endfunction

  initial begin
    vec_t vecs[15];
    logic mRdy, mEn, mDone, mBusy;
    logic [2:0] mDir;
    logic [7:0] mData;
    logic [2:0] dirK;
    logic [7:0] datK;
    logic v;
    logic [2:0] rop;
    logic [3:0] rcnt;
    logic [7:0] rdat;
    int popC;
    cmd_t cmd;

`ifdef SHIFT_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    vecs[0]  = '{1'b0, 1'b1, 3'd3, 4'd5, 8'hA5, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 3'd3, 4'd5, 8'hA5, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 3'd3, 4'd5, 8'hA5, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 3'd3, 4'd5, 8'hA5, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b1, 1'b0, 3'd3, 8'hA5, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 3'd4, 4'd0, 8'h3C, 1'b1, 1'b0, 3'd3, 8'hA5, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b1, 1'b0, 3'd3, 8'hA5, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b1, 1'b0, 3'd4, 8'h3C, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b1, 1'b0, 3'd4, 8'h3C, 1'b0, 1'b0};

    // Reset held with a command offered, then a count=5 and a count=0 command.
    applyStimulus(1'b0, 1'b1, 3'd3, 4'd5, 8'hA5);
    nextCycle();
    for (int i = 0; i < 15; i++) begin
      checkAll($sformatf("vec%0d", i), vecs[i].eRdy, vecs[i].eEn, vecs[i].eDir, vecs[i].eData,
               vecs[i].eDone, vecs[i].eBusy);
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].op, vecs[i].cnt, vecs[i].data);
      nextCycle();
    end

    // Three back-to-back commands: counts 2, 1, 3.
    for (int k = 0; k < 15; k++) begin
      if (k < 2)      begin dirK = 3'd4; datK = 8'h3C; end
      else if (k < 6) begin dirK = 3'd1; datK = 8'h11; end
      else if (k < 9) begin dirK = 3'd2; datK = 8'h22; end
      else            begin dirK = 3'd5; datK = 8'h33; end
      checkAll($sformatf("b2b%0d", k), !(k >= 3 && k <= 5),
               (k == 2 || k == 3 || k == 6 || k == 9 || k == 10 || k == 11), dirK, datK,
               (k == 4 || k == 7 || k == 12), (k >= 1 && k <= 12));
      case (k)
        0:       applyStimulus(1'b1, 1'b1, 3'd1, 4'd2, 8'h11);
        1:       applyStimulus(1'b1, 1'b1, 3'd2, 4'd1, 8'h22);
        2:       applyStimulus(1'b1, 1'b1, 3'd5, 4'd3, 8'h33);
        default: applyStimulus(1'b1, 1'b0, 3'd0, 4'd0, 8'h00);
      endcase
      nextCycle();
    end

    // Reset during the 4th enable cycle of a count=15 command with another command queued.
    for (int m = 0; m < 13; m++) begin
      if (m == 5) checkOutput("rstRun.enable_before", 32'(bus.sr_enable), 32'd1);
      if (m == 6) checkAll("rstRun.after", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      if (m > 6) begin
        checkOutput($sformatf("rstRun.enable%0d", m), 32'(bus.sr_enable), 32'd0);
        checkOutput($sformatf("rstRun.done%0d", m), 32'(bus.done), 32'd0);
        checkOutput($sformatf("rstRun.busy%0d", m), 32'(bus.busy), 32'd0);
      end
      case (m)
        0:       applyStimulus(1'b1, 1'b1, 3'd6, 4'd15, 8'h5A);
        1:       applyStimulus(1'b1, 1'b1, 3'd2, 4'd2, 8'h77);
        5:       applyStimulus(1'b0, 1'b0, 3'd0, 4'd0, 8'h00);
        default: applyStimulus(1'b1, 1'b0, 3'd0, 4'd0, 8'h00);
      endcase
      nextCycle();
    end

`ifdef SHIFT_SEQ_ABORT_EN
    // Abort at the 2nd enable cycle of a count=8 command with one command queued.
    for (int a = 0; a < 13; a++) begin
      if (a == 3) checkOutput("abort.enable_before", 32'(bus.sr_enable), 32'd1);
      if (a == 4) checkAll("abort.done", 1'b1, 1'b0, 3'd7, 8'h99, 1'b1, 1'b1);
      if (a > 4) checkAll($sformatf("abort.after%0d", a), 1'b1, 1'b0, 3'd7, 8'h99, 1'b0, 1'b0);
      bus.abort = (a == 3);
      case (a)
        0:       applyStimulus(1'b1, 1'b1, 3'd7, 4'd8, 8'h99);
        1:       applyStimulus(1'b1, 1'b1, 3'd1, 4'd3, 8'h44);
        default: applyStimulus(1'b1, 1'b0, 3'd0, 4'd0, 8'h00);
      endcase
      nextCycle();
    end
    bus.abort = 1'b0;
`endif

    // Randomized traffic from a fresh reset, checked against the schedule model.
    applyStimulus(1'b0, 1'b0, 3'd0, 4'd0, 8'h00);
    nextCycle();
    nextCycle();
    applyStimulus(1'b1, 1'b0, 3'd0, 4'd0, 8'h00);
    modelQ.delete();
    lastDone = -10;
    for (int c = 0; c < 600; c++) begin
      modelAt(c, mRdy, mEn, mDir, mData, mDone, mBusy);
      checkAll($sformatf("rnd%0d", c), mRdy, mEn, mDir, mData, mDone, mBusy);
      v    = ((c / 100) % 2 == 0) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 10);
      rop  = 3'($urandom_range(0, 7));
      rcnt = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      rdat = 8'($urandom_range(0, 255));
      applyStimulus(1'b1, v, rop, rcnt, rdat);
      if (v && mRdy) begin
        popC     = (c + 1 > lastDone + 1) ? c + 1 : lastDone + 1;
        cmd.op   = rop;
        cmd.cnt  = int'(rcnt);
        cmd.data = rdat;
        cmd.acc  = c;
        cmd.pop  = popC;
        modelQ.push_back(cmd);
        lastDone = popC + int'(rcnt) + 1;
      end
      nextCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
